dmem_arbiter: RTL and testbench

//  Data-memory access controller for the MEM stage. Shares one single-port data memory between
//  the CPU (EX/MEM register outputs) and a DMA/peripheral requester, sequences multi-cycle accesses,
//  and stalls the pipeline (PC, IF/ID, ID/EX, EX/MEM hold) until the CPU access completes.

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: MEM-stage data-memory access controller.
// Shares one single-port data memory between the CPU (EX/MEM register) and a
// DMA/peripheral requester, runs one access at a time and holds the pipeline
// until the CPU access has completed.
//
// Optional build macro: DMA_FAIR_EN
//   defined   - a starvation counter forces a DMA grant after FAIR_LIMIT
//               consecutive CPU grants taken while DMA was waiting.
//   undefined - strict CPU priority; DMA only wins an idle cycle without cpu_req.
//
// Handshakes:
//   memory : mem_req/mem_we/mem_addr/mem_wdata are registered and held stable
//            until a single-cycle mem_ready; mem_rdata is valid with mem_ready.
//   dma    : dma_req and its payload are held until the one-cycle dma_ack;
//            dma_rdata is valid in the dma_ack cycle.
//   cpu    : cpu_rd/cpu_wr and payload are held while cpu_stall=1; cpu_rdata is
//            valid in the cycle cpu_stall falls.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FAIR_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2
  } state_t;

  state_t state;

  logic cpu_req;
  logic cpu_done;
  logic dma_done;
  logic fair_force;
  logic grant_dma;
  logic grant_cpu;

  if (FAIR_LIMIT < 1) begin : g_bad_limit
    $error("dmem_arbiter: FAIR_LIMIT must be at least 1");
  end

  // Completion is recognised only in the owning access state, so a stray
  // mem_ready while idle has no effect at all.
  assign cpu_req   = cpu_rd | cpu_wr;
  assign cpu_done  = (state == CPU_ACC) & mem_ready;
  assign dma_done  = (state == DMA_ACC) & mem_ready;

  // Stall drops in the ready cycle itself so the EX/MEM register can advance
  // on the same edge that returns the FSM to IDLE.
  assign cpu_stall = cpu_req & ~cpu_done;
  assign cpu_rdata = mem_rdata;
  assign dma_ack   = dma_done;
  assign dma_rdata = mem_rdata;
  assign dbg_state = state;

`ifdef DMA_FAIR_EN
  localparam int CW = $clog2(FAIR_LIMIT + 1);

  logic [CW-1:0] starve_cnt;

  assign fair_force = (starve_cnt == CW'(FAIR_LIMIT));

  // Count CPU grants taken while DMA is waiting; any DMA grant or an idle
  // dma_req clears it, and it stops at FAIR_LIMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!dma_req || grant_dma) begin
      starve_cnt <= '0;
    end else if (grant_cpu && (starve_cnt != CW'(FAIR_LIMIT))) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  // Grant decisions are only taken in IDLE; the CPU wins ties unless DMA has
  // been starved long enough to force its turn.
  assign grant_dma = (state == IDLE) & dma_req & (~cpu_req | fair_force);
  assign grant_cpu = (state == IDLE) & cpu_req & ~grant_dma;

  // Access sequencer: latch the winner into the memory registers, then hold
  // them until mem_ready and drop back to IDLE for one bubble cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dma) begin
            mem_req   <= 1'b1;
            mem_we    <= dma_we;
            mem_addr  <= dma_addr;
            mem_wdata <= dma_wdata;
            state     <= DMA_ACC;
          end else if (grant_cpu) begin
            mem_req   <= 1'b1;
            mem_we    <= cpu_wr;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            state     <= CPU_ACC;
          end
        end
        CPU_ACC, DMA_ACC: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Memory-side request fields must stay frozen while an access waits.
  a_mem_hold: assert property (@(posedge clk) disable iff (!reset)
    (mem_req && !mem_ready) |=> (mem_req && $stable(mem_addr) && $stable(mem_we) && $stable(mem_wdata)));

  // Only one requester can complete in a given cycle.
  a_one_done: assert property (@(posedge clk) disable iff (!reset)
    !(cpu_done && dma_done));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter.
// Expected accesses are pushed in the order the arbitration rules say they
// must reach memory; a negedge monitor pops them as grants appear and checks
// completion data, stall length, ack pulse width and the idle bubble.
module tb_dmem_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int FAIR_LIMIT = 4;

  typedef struct packed {
    logic              dma;
    logic              we;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic signed [7:0] stall;   // >0 exact stall cycles, 0 stall tracks access length, <0 unchecked
  } acc_t;

  localparam int W = $bits(acc_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          dma_ack;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;
  logic [1:0]    dbg_state;

  dmem_arbiter #(.AW(AW), .DW(DW), .FAIR_LIMIT(FAIR_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] init_pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [logic [31:0]];
  int  next_wait  = -1;   // -1 picks a random 0..3 wait per access
  bit  spur_ready = 1'b0;
  bit  busy;
  int  remain;
  int  w;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_pat(a);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      busy      <= 1'b0;
      remain    <= 0;
    end else begin
      mem_ready <= spur_ready;
      mem_rdata <= $urandom;
      if (!mem_req) begin
        busy <= 1'b0;
      end else if (!mem_ready) begin
        if (!busy) begin
          w = (next_wait >= 0) ? next_wait : $urandom_range(0, 3);
          if (w == 0) begin
            mem_ready <= 1'b1;
            if (mem_we) mem_arr[mem_addr] = mem_wdata;
            else mem_rdata <= mem_read(mem_addr);
          end else begin
            busy   <= 1'b1;
            remain <= w - 1;
          end
        end else if (remain == 0) begin
          busy      <= 1'b0;
          mem_ready <= 1'b1;
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          else mem_rdata <= mem_read(mem_addr);
        end else begin
          remain <= remain - 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [W-1:0] exp_q[$];

  function automatic void push_exp(input logic dma, input logic we, input logic [31:0] a,
                                   input logic [31:0] d, input int st);
    acc_t e;
    e.dma   = dma;
    e.we    = we;
    e.addr  = a;
    e.wdata = d;
    e.stall = 8'(st);
    e.rdata = ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
    if (we) ref_mem[a] = d;
    exp_q.push_back(e);
  endfunction

  acc_t cur;
  bit   inflight;
  bit   prev_req;
  bit   bubble_chk;
  int   stall_run;
  int   req_run;

  always @(negedge clk) begin
    if (!reset) begin
      inflight   = 1'b0;
      prev_req   = 1'b0;
      bubble_chk = 1'b0;
      stall_run  = 0;
      req_run    = 0;
    end else begin
      if (bubble_chk) begin
        chk("bubble_req", 32'(mem_req), 32'd0);
        chk("ack_pulse", 32'(dma_ack), 32'd0);
        bubble_chk = 1'b0;
      end
      if (mem_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_grant: addr %h with empty queue (t=%0t)", mem_addr, $time);
        end else begin
          cur = exp_q.pop_front();
          chk("grant_we", 32'(mem_we), 32'(cur.we));
          chk("grant_addr", mem_addr, cur.addr);
          if (cur.we) chk("grant_wdata", mem_wdata, cur.wdata);
          inflight = 1'b1;
          req_run  = 0;
        end
      end
      if (mem_req) req_run++;
      if (mem_req && mem_ready && inflight) begin
        if (cur.dma) begin
          chk("dma_ack", 32'(dma_ack), 32'd1);
          if (!cur.we) chk("dma_rdata", dma_rdata, cur.rdata);
        end else begin
          chk("stall_fall", 32'(cpu_stall), 32'd0);
          chk("no_dma_ack", 32'(dma_ack), 32'd0);
          if (!cur.we) chk("cpu_rdata", cpu_rdata, cur.rdata);
          if (cur.stall > 0) chk("stall_len", 32'(stall_run), 32'(int'(cur.stall)));
          else if (cur.stall == 0) chk("stall_vs_access", 32'(stall_run), 32'(req_run));
        end
        inflight   = 1'b0;
        bubble_chk = 1'b1;
      end
      stall_run = cpu_stall ? stall_run + 1 : 0;
      prev_req  = mem_req;
    end
  end

  // ---------------- drivers ----------------
  // Called at posedge+1; returns at posedge+1 after the completing edge.
  task automatic cpu_drive(input logic we, input logic [31:0] a, input logic [31:0] d, input bit hold);
    int n;
    cpu_rd = ~we; cpu_wr = we; cpu_addr = a; cpu_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (cpu_stall && n < 300);
    if (cpu_stall) fail_now("cpu_timeout");
    @(posedge clk); #1;
    if (!hold) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
  endtask

  task automatic dma_drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    int n;
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!dma_ack && n < 400);
    if (!dma_ack) fail_now("dma_timeout");
    @(posedge clk); #1;
    dma_req = 1'b0;
  endtask

  task automatic finish_report();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
  endtask

  initial begin
    #300000;
    fail_now("watchdog");
    finish_report();
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, gap, kind, dma_pos;
    logic [31:0] a, d;
    logic we_r;

    reset = 1'b0;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_stall_follows_req", 32'(cpu_stall), 32'd1);
    cpu_rd = 1'b0;
    #1;
    chk("rst_stall_idle", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // CPU load, memory answers immediately
    next_wait = 0;
    push_exp(1'b0, 1'b0, 32'h100, 32'h0, 2);
    cpu_drive(1'b0, 32'h100, 32'h0, 1'b0);

    // CPU store with three wait cycles
    next_wait = 3;
    push_exp(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 5);
    cpu_drive(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    next_wait = -1;

    // DMA reads the stored word back
    push_exp(1'b1, 1'b0, 32'h40, 32'h0, -1);
    dma_drive(1'b0, 32'h40, 32'h0);

    // simultaneous requests: CPU first, DMA after the bubble
    push_exp(1'b0, 1'b0, 32'h40, 32'h0, -1);
    push_exp(1'b1, 1'b1, 32'h80, 32'h1234_5678, -1);
    fork
      cpu_drive(1'b0, 32'h40, 32'h0, 1'b0);
      dma_drive(1'b1, 32'h80, 32'h1234_5678);
    join

    // continuous CPU demand with DMA waiting
`ifdef DMA_FAIR_EN
    dma_pos = FAIR_LIMIT;
`else
    dma_pos = 6;
`endif
    for (int i = 0; i < 6; i++) begin
      if (i == dma_pos) push_exp(1'b1, 1'b1, 32'h300, 32'h5A5A_A5A5, -1);
      push_exp(1'b0, 1'b0, 32'h200 + 32'(4 * i), 32'h0, -1);
    end
    if (dma_pos == 6) push_exp(1'b1, 1'b1, 32'h300, 32'h5A5A_A5A5, -1);
    fork
      begin
        for (int i = 0; i < 6; i++) cpu_drive(1'b0, 32'h200 + 32'(4 * i), 32'h0, i < 5);
      end
      dma_drive(1'b1, 32'h300, 32'h5A5A_A5A5);
    join

    // reset in the middle of a CPU access, then the held request is re-granted
    next_wait = 3;
    push_exp(1'b0, 1'b0, 32'h500, 32'h0, -1);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h500; cpu_wdata = 32'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 50);
    if (!mem_req) fail_now("rst_mid_grant");
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_mid_stall", 32'(cpu_stall), 32'd1);
    next_wait = -1;
    push_exp(1'b0, 1'b0, 32'h500, 32'h0, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (cpu_stall && n < 50);
    if (cpu_stall) fail_now("rst_regrant");
    @(posedge clk); #1;
    cpu_rd = 1'b0;

    // stray mem_ready while idle
    @(posedge clk); #1;
    spur_ready = 1'b1;
    @(posedge clk); #1;
    spur_ready = 1'b0;
    @(negedge clk);
    chk("spur_stall", 32'(cpu_stall), 32'd0);
    chk("spur_ack", 32'(dma_ack), 32'd0);
    chk("spur_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("spur_req_after", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    next_wait = 0;
    push_exp(1'b0, 1'b0, 32'h100, 32'h0, 2);
    cpu_drive(1'b0, 32'h100, 32'h0, 1'b0);
    next_wait = -1;

    // randomized mix
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      a    = 32'h1000 + 32'($urandom_range(0, 7) * 4);
      d    = $urandom;
      we_r = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        push_exp(1'b0, we_r, a, d, 0);
        cpu_drive(we_r, a, d, 1'b0);
      end else if (kind == 1) begin
        push_exp(1'b1, we_r, a, d, -1);
        dma_drive(we_r, a, d);
      end else begin
        logic [31:0] a2, d2;
        logic we2;
        a2  = 32'h1000 + 32'($urandom_range(0, 7) * 4);
        d2  = $urandom;
        we2 = 1'($urandom_range(0, 1));
        push_exp(1'b0, we_r, a, d, -1);
        push_exp(1'b1, we2, a2, d2, -1);
        fork
          cpu_drive(we_r, a, d, 1'b0);
          dma_drive(we2, a2, d2);
        join
      end
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    finish_report();
    $finish;
  end

endmodule
